// File: rtl/sel_scan_ctrl_if.sv
// Control/status bundle between a scan requester and sel_scan_ctrl.
// The master drives the scan request and configuration; the slave (the controller) returns select and pulses.
interface sel_scan_ctrl_if #(parameter int DWELL_W = 8);
  logic               start;
  logic               stop;
  logic               mode;
  logic [7:0]         en_mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               active;
  logic               step;
  logic               wrap;
  logic               done;

  modport master (
    output start, stop, mode, en_mask, dwell,
    input  sel, sel_valid, active, step, wrap, done
  );

  modport slave (
    input  start, stop, mode, en_mask, dwell,
    output sel, sel_valid, active, step, wrap, done
  );
endinterface

// File: rtl/sel_scan_ctrl.sv
// Sequenced select generator for the 3-to-8 decoder: walks the enabled channels of a mask,
// holding each for a programmable dwell, in one-shot or continuous mode.
module sel_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  sel_scan_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_r;
  logic [7:0]         mask_r;
  logic               mode_r;
  logic [DWELL_W-1:0] reload_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [2:0]         sel_r;
  logic               sel_valid_r;
  logic               step_r;
  logic               wrap_r;
  logic               done_r;

  logic [DWELL_W-1:0] reload_in_s;
  logic [2:0]         first_in_s;
  logic [2:0]         first_lat_s;
  logic               next_found_s;
  logic [2:0]         next_idx_s;
  logic               start_ok_s;

  // Lowest set bit of the mask; 0 when the mask is empty.
  function automatic logic [2:0] lowest_chan(input logic [7:0] mask);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      res = mask[i] ? 3'(i) : res;
    end
    return res;
  endfunction

  // {found, index} of the nearest enabled channel strictly above cur, no wrap.
  function automatic logic [3:0] next_chan(input logic [7:0] mask, input logic [2:0] cur);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      res = (mask[i] && (3'(i) > cur)) ? {1'b1, 3'(i)} : res;
    end
    return res;
  endfunction

  // Channel search and start qualification, all single-cycle combinational.
  always_comb begin
    reload_in_s = {DWELL_W{1'b0}};
    if (bus.dwell != {DWELL_W{1'b0}}) begin
      reload_in_s = bus.dwell - DWELL_W'(1'b1);
    end else begin
      reload_in_s = {DWELL_W{1'b0}};
    end
    first_in_s                 = lowest_chan(bus.en_mask);
    first_lat_s                = lowest_chan(mask_r);
    {next_found_s, next_idx_s} = next_chan(mask_r, sel_r);
    start_ok_s = bus.start && !bus.stop && (bus.en_mask != 8'h00);
  end

  // Scan state machine; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      mask_r      <= 8'h00;
      mode_r      <= 1'b0;
      reload_r    <= {DWELL_W{1'b0}};
      cnt_r       <= {DWELL_W{1'b0}};
      sel_r       <= 3'd0;
      sel_valid_r <= 1'b0;
      step_r      <= 1'b0;
      wrap_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      step_r <= 1'b0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            mask_r      <= bus.en_mask;
            mode_r      <= bus.mode;
            reload_r    <= reload_in_s;
            cnt_r       <= reload_in_s;
            sel_r       <= first_in_s;
            sel_valid_r <= 1'b1;
            step_r      <= 1'b1;
            state_r     <= SCAN;
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (bus.stop) begin
            sel_r       <= 3'd0;
            sel_valid_r <= 1'b0;
            cnt_r       <= {DWELL_W{1'b0}};
            state_r     <= IDLE;
          end else if (cnt_r != {DWELL_W{1'b0}}) begin
            cnt_r <= cnt_r - DWELL_W'(1'b1);
          end else if (next_found_s) begin
            sel_r  <= next_idx_s;
            step_r <= 1'b1;
            cnt_r  <= reload_r;
          end else if (mode_r) begin
            // A single-channel mask lands back on the same channel, still flagged as a wrap.
            sel_r  <= first_lat_s;
            step_r <= 1'b1;
            wrap_r <= 1'b1;
            cnt_r  <= reload_r;
          end else begin
            sel_r       <= 3'd0;
            sel_valid_r <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          sel_r       <= 3'd0;
          sel_valid_r <= 1'b0;
          cnt_r       <= {DWELL_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.sel       = sel_r;
  assign bus.sel_valid = sel_valid_r;
  assign bus.active    = sel_valid_r;
  assign bus.step      = step_r;
  assign bus.wrap      = wrap_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Scoreboard bench for sel_scan_ctrl: directed scans push cycle-stamped expected outputs,
// a negedge monitor pops one entry per presented output.
module tb_sel_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_cyc = 0;

  typedef struct {
    logic [2:0] sel;
    logic       valid;
    logic       step;
    logic       wrap;
    logic       done;
    int         cyc;
  } exp_t;

  exp_t q[$];

  sel_scan_ctrl_if #(.DWELL_W(8)) bus ();

  sel_scan_ctrl #(.DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each cycle with any live output consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.sel_valid || bus.done || bus.step || bus.wrap)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d got sel=%0d valid=%0b step=%0b wrap=%0b done=%0b expected no output",
                 cyc, bus.sel, bus.sel_valid, bus.step, bus.wrap, bus.done);
      end else begin
        e = q.pop_front();
        if (bus.sel !== e.sel || bus.sel_valid !== e.valid || bus.active !== e.valid ||
            bus.step !== e.step || bus.wrap !== e.wrap || bus.done !== e.done || cyc != e.cyc) begin
          failures++;
          $display("FAIL scoreboard got cyc=%0d sel=%0d valid=%0b active=%0b step=%0b wrap=%0b done=%0b expected cyc=%0d sel=%0d valid=%0b step=%0b wrap=%0b done=%0b",
                   cyc, bus.sel, bus.sel_valid, bus.active, bus.step, bus.wrap, bus.done,
                   e.cyc, e.sel, e.valid, e.step, e.wrap, e.done);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_sel"}, {5'd0, bus.sel}, 8'd0);
    chk({name, "_valid"}, {6'd0, bus.active, bus.sel_valid}, 8'd0);
    chk({name, "_pulses"}, {5'd0, bus.step, bus.wrap, bus.done}, 8'd0);
  endtask

  // Called at posedge+1 just before the tick that samples start.
  task automatic begin_scan();
    exp_cyc = cyc + 1;
  endtask

  task automatic push_ch(input logic [2:0] ch, input int d, input logic wr);
    for (int k = 0; k < d; k++) begin
      q.push_back('{ch, 1'b1, (k == 0), ((k == 0) && wr), 1'b0, exp_cyc});
      exp_cyc++;
    end
  endtask

  task automatic push_done();
    q.push_back('{3'd0, 1'b0, 1'b0, 1'b0, 1'b1, exp_cyc});
    exp_cyc++;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout got pending=%0d expected pending=0", name, q.size());
      q.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.mode    = 1'b0;
    bus.en_mask = 8'h00;
    bus.dwell   = 8'd0;
    repeat (2) tick();
    chk_idle("reset");
    rst = 1'b0;
    repeat (3) tick();
    chk_idle("post_reset_idle");

    // One-shot A5, dwell 3; config changes and a re-start mid-scan are ignored.
    bus.en_mask = 8'hA5;
    bus.dwell   = 8'd3;
    bus.mode    = 1'b0;
    begin_scan();
    push_ch(3'd0, 3, 1'b0);
    push_ch(3'd2, 3, 1'b0);
    push_ch(3'd5, 3, 1'b0);
    push_ch(3'd7, 3, 1'b0);
    push_done();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.en_mask = 8'h01;
    bus.dwell   = 8'd1;
    bus.mode    = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_drain("oneshot_a5", 40);
    repeat (2) tick();

    // Continuous 81 with dwell 0: toggles every cycle, wrap on each return to 0.
    bus.en_mask = 8'h81;
    bus.dwell   = 8'd0;
    bus.mode    = 1'b1;
    begin_scan();
    push_ch(3'd0, 1, 1'b0);
    push_ch(3'd7, 1, 1'b0);
    push_ch(3'd0, 1, 1'b1);
    push_ch(3'd7, 1, 1'b0);
    push_ch(3'd0, 1, 1'b1);
    push_ch(3'd7, 1, 1'b0);
    push_ch(3'd0, 1, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_idle("cont_stop");
    chk("cont_pending", 8'(q.size()), 8'd0);

    // Stop while sel=3 in an FF scan with dwell 4.
    bus.en_mask = 8'hFF;
    bus.dwell   = 8'd4;
    bus.mode    = 1'b0;
    begin_scan();
    push_ch(3'd0, 4, 1'b0);
    push_ch(3'd1, 4, 1'b0);
    push_ch(3'd2, 4, 1'b0);
    push_ch(3'd3, 2, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (13) tick();
    chk("stop_pre_sel", {5'd0, bus.sel}, 8'd3);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_idle("stop_ff");
    tick();
    chk("stop_no_done", {7'd0, bus.done}, 8'd0);
    chk("stop_pending", 8'(q.size()), 8'd0);

    // Start with an empty mask is ignored.
    bus.en_mask = 8'h00;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk_idle("zero_mask");

    // Start and stop together in idle: stop wins.
    bus.en_mask = 8'hFF;
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick();
    chk_idle("start_and_stop");

    // Back-to-back one-shot passes with start held through the first done.
    bus.en_mask = 8'h12;
    bus.dwell   = 8'd2;
    bus.mode    = 1'b0;
    begin_scan();
    push_ch(3'd1, 2, 1'b0);
    push_ch(3'd4, 2, 1'b0);
    push_done();
    push_ch(3'd1, 2, 1'b0);
    push_ch(3'd4, 2, 1'b0);
    push_done();
    bus.start = 1'b1;
    tick();
    repeat (5) tick();
    bus.start = 1'b0;
    wait_drain("back_to_back", 30);
    repeat (2) tick();

    // Asynchronous reset mid-cycle during a continuous scan.
    bus.en_mask = 8'hFF;
    bus.dwell   = 8'd4;
    bus.mode    = 1'b1;
    begin_scan();
    push_ch(3'd0, 2, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    #1 chk_idle("async_reset");
    chk("reset_pending", 8'(q.size()), 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    chk_idle("after_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sel_scan_ctrl.md
# sel_scan_ctrl

Sequenced select generator that drives the 3-bit `sel` input of the team's 3-to-8 one-hot decoder. It steps through the enabled channels of an 8-bit mask and holds each channel for a programmable number of clock cycles (dwell), in either one-shot or continuous mode. It sits directly upstream of the decoder: `sel` feeds the decoder's `sel`, and `sel_valid` gates the decoder outputs downstream.

## Interface
- `DWELL_W`, default 8: width of the dwell count.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: level sampled each edge; begins a scan when the block is idle.
- `stop` input 1: aborts the scan in progress.
- `mode` input 1: 0 = one-shot (one pass), 1 = continuous (repeat passes).
- `en_mask` input 8: bit i set = channel i is visited.
- `dwell` input DWELL_W: cycles to hold each channel; 0 is treated as 1.
- `sel` output 3: current channel number, to the decoder.
- `sel_valid` output 1: `sel` is a live scan channel.
- `active` output 1: a scan is in progress (equal to `sel_valid`).
- `step` output 1: one-cycle pulse in the first cycle a channel is presented.
- `wrap` output 1: one-cycle pulse, continuous mode only, when the scan returns to the lowest enabled channel.
- `done` output 1: one-cycle pulse when a one-shot pass completes.

## Operation
- States: IDLE and SCAN.
- Reset values, all outputs: `sel`=0, `sel_valid`=0, `active`=0, `step`=0, `wrap`=0, `done`=0. State is IDLE and the internal counter is 0.
- **IDLE, start accepted.** When `start`=1, `stop`=0 and `en_mask`≠0:
  - latch `en_mask`, `mode`, and D = max(`dwell`,1);
  - set `sel` to the lowest set bit of the mask;
  - set `sel_valid`=1 and `step`=1;
  - load dwell counter = D-1;
  - go to SCAN.
- **IDLE, start ignored.** `start` with `en_mask`=0 is ignored: no state change, no pulses.
- **SCAN, holding.** While counter≠0, decrement it and hold `sel`.
- **SCAN, end of dwell (counter=0).** Search the latched mask upward from `sel`+1, wrapping at 7→0:
  - Found a higher channel: `sel` takes it, `step`=1, counter reloads to D-1.
  - Search wrapped, continuous mode: `sel` takes the lowest enabled channel, `step`=1, `wrap`=1, counter reloads to D-1.
  - Search wrapped, one-shot mode: go to IDLE with `sel`=0, `sel_valid`=0, `done`=1.
- **Single-channel mask.** The wrap search returns the same channel. In continuous mode, `step` and `wrap` assert every D cycles.
- **Latched configuration.** `en_mask`, `mode` and `dwell` changes during SCAN have no effect. `start` during SCAN is ignored.
- **Stop.** `stop`=1 in SCAN: next edge goes to IDLE, `sel`=0, `sel_valid`=0, no `done`. `stop` and `start` together in IDLE: stop wins, the scan does not begin.
- **Reset mid-scan.** Immediately forces the reset values; no `done` pulse.
- **Next-channel search.** Combinational priority search over 8 bits; completes in a single cycle.

## Timing
- All outputs are registered.
- `start` sampled at edge k: `sel_valid`, `step` and the first `sel` are visible in the cycle after edge k.
- Each channel is held for exactly D cycles, so consecutive channel changes are D edges apart.
- One-shot with N enabled channels:
  - `sel_valid` is high for exactly N·D cycles;
  - `done` is high in the single cycle immediately after, the same cycle `sel_valid` is low;
  - a new `start` is accepted on the edge ending the `done` cycle.
- `step` coincides with every `sel` change and with the first channel. `wrap` coincides with `step`.
- `stop` latency: 1 edge.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle during a scan -> all outputs 0 immediately; after release, the block stays idle until `start`.
- **One-shot.** `en_mask`=8'hA5, `dwell`=3, `mode`=0, pulse `start` -> `sel` sequence 0,0,0,2,2,2,5,5,5,7,7,7 with `sel_valid`=1 for 12 cycles and `step` on cycles 1,4,7,10; then `done`=1 for 1 cycle and `sel`=0.
- **Continuous with dwell 0.** `en_mask`=8'h81, `dwell`=0, `mode`=1 -> `sel` alternates 0,7,0,7 every cycle, `step` high every cycle, `wrap` high on each return to 0 (not on the first channel); `done` never asserts.
- **Stop and zero mask.** Scan with `en_mask`=8'hFF, `dwell`=4; assert `stop` while `sel`=3 -> next cycle `sel_valid`=0, `sel`=0, `done`=0. Separately, `start` with `en_mask`=0 -> outputs unchanged.
- **Ignored inputs.** Change `en_mask` to 8'h01 and `dwell` to 1 mid-scan, and re-pulse `start` -> original sequence and dwell continue unaltered.
- **Simultaneous and back-to-back.** `start` and `stop` in the same idle cycle -> no scan. `start` held high through `done` -> a new pass begins in the cycle after `done`.
